// File: rtl/npu_sigmoid_fifo.sv
// Feedback FIFO for sigmoid results routed back to the PE input bus; strobe is delayed to align with sigmoid data.
// Latency: issue-to-stored SIGMOID_LATENCY+1 cycles, push-to-visible 1 cycle, pop-to-next-head 1 cycle.
// Backpressure: none upstream; pushes into a full FIFO are dropped (sticky overflow), pops on empty set sticky underflow.
module npu_sigmoid_fifo #(
    parameter int DATA_W          = 16,
    parameter int DEPTH           = 16,
    parameter int ADDR_W          = 4,
    parameter int SIGMOID_LATENCY = 0
) (
    input  logic              CLK,
    input  logic              npu_rst,
    input  logic [DATA_W-1:0] npu_sigmoid_dout,
    input  logic              npu_sched_sigmoid_input_en,
    input  logic              npu_sched_sigmoid_dest_sel,
    input  logic              npu_sched_sfifo_rd_en,
    output logic [DATA_W-1:0] npu_sfifo_dout,
    output logic              npu_sfifo_empty,
    output logic              npu_sfifo_full,
    output logic [ADDR_W:0]   npu_sfifo_count,
    output logic              npu_sfifo_overflow,
    output logic              npu_sfifo_underflow
);

    logic              push_raw;
    logic              push_req;
    logic              acc_push;
    logic              acc_pop;
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign push_raw = npu_sched_sigmoid_input_en & ~npu_sched_sigmoid_dest_sel;

    // Strobe delay line; clearing it on reset drops in-flight and reset-cycle strobes.
    generate
        if (SIGMOID_LATENCY == 0) begin : g_no_dly
            assign push_req = push_raw;
        end else begin : g_dly
            logic [SIGMOID_LATENCY-1:0] dly;
            always_ff @(posedge CLK) begin
                if (npu_rst) begin
                    dly <= '0;
                end else begin
                    dly <= (dly << 1) | SIGMOID_LATENCY'(push_raw);
                end
            end
            assign push_req = dly[SIGMOID_LATENCY-1];
        end
    endgenerate

    // A full FIFO is never empty, so a pop in the same cycle always frees a slot.
    assign acc_pop    = npu_sched_sfifo_rd_en & ~npu_sfifo_empty;
    assign acc_push   = push_req & (~npu_sfifo_full | npu_sched_sfifo_rd_en);
    assign count_next = npu_sfifo_count + {{ADDR_W{1'b0}}, acc_push} - {{ADDR_W{1'b0}}, acc_pop};

    always_ff @(posedge CLK) begin
        if (npu_rst) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            npu_sfifo_count     <= '0;
            npu_sfifo_empty     <= 1'b1;
            npu_sfifo_full      <= 1'b0;
            npu_sfifo_overflow  <= 1'b0;
            npu_sfifo_underflow <= 1'b0;
        end else begin
            if (acc_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (acc_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && !acc_push) begin
                npu_sfifo_overflow <= 1'b1;
            end
            if (npu_sched_sfifo_rd_en && npu_sfifo_empty) begin
                npu_sfifo_underflow <= 1'b1;
            end
            npu_sfifo_count <= count_next;
            npu_sfifo_empty <= (count_next == '0);
            npu_sfifo_full  <= (count_next == (ADDR_W+1)'(DEPTH));
        end
    end

    always_ff @(posedge CLK) begin
        if (acc_push && !npu_rst) begin
            mem[wr_ptr] <= npu_sigmoid_dout;
        end
    end

    assign npu_sfifo_dout = npu_sfifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_npu_sigmoid_fifo.sv
// Bench for npu_sigmoid_fifo: queue-model scoreboard on a zero-latency instance, directed checks on a latency-2 instance.
module tb_npu_sigmoid_fifo;

    logic        CLK;
    // Zero-latency instance
    logic        rst0, en0, ds0, rd0;
    logic [15:0] din0, dout0;
    logic        empty0, full0, ovf0, unf0;
    logic [4:0]  cnt0;
    // Latency-2 instance
    logic        rst1, en1, ds1, rd1;
    logic [15:0] din1, dout1;
    logic        empty1, full1, ovf1, unf1;
    logic [4:0]  cnt1;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] sb[$];
    logic        m_ovf, m_unf;

    npu_sigmoid_fifo #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .SIGMOID_LATENCY(0)) dut0 (
        .CLK                        (CLK),
        .npu_rst                    (rst0),
        .npu_sigmoid_dout           (din0),
        .npu_sched_sigmoid_input_en (en0),
        .npu_sched_sigmoid_dest_sel (ds0),
        .npu_sched_sfifo_rd_en      (rd0),
        .npu_sfifo_dout             (dout0),
        .npu_sfifo_empty            (empty0),
        .npu_sfifo_full             (full0),
        .npu_sfifo_count            (cnt0),
        .npu_sfifo_overflow         (ovf0),
        .npu_sfifo_underflow        (unf0)
    );

    npu_sigmoid_fifo #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .SIGMOID_LATENCY(2)) dut1 (
        .CLK                        (CLK),
        .npu_rst                    (rst1),
        .npu_sigmoid_dout           (din1),
        .npu_sched_sigmoid_input_en (en1),
        .npu_sched_sigmoid_dest_sel (ds1),
        .npu_sched_sfifo_rd_en      (rd1),
        .npu_sfifo_dout             (dout1),
        .npu_sfifo_empty            (empty1),
        .npu_sfifo_full             (full1),
        .npu_sfifo_count            (cnt1),
        .npu_sfifo_overflow         (ovf1),
        .npu_sfifo_underflow        (unf1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compare all observable state of dut0 against the queue model.
    task automatic check_state0(input string tag);
        chk({tag, ":count"}, 32'(cnt0), 32'(sb.size()));
        chk({tag, ":empty"}, 32'(empty0), 32'(sb.size() == 0));
        chk({tag, ":full"}, 32'(full0), 32'(sb.size() == 16));
        chk({tag, ":ovf"}, 32'(ovf0), 32'(m_ovf));
        chk({tag, ":unf"}, 32'(unf0), 32'(m_unf));
        chk({tag, ":dout"}, 32'(dout0), (sb.size() > 0) ? 32'(sb[0]) : 32'h0);
    endtask

    // One cycle on dut0: expected pop data leaves the scoreboard, expected push data enters it.
    task automatic step0(input logic en, input logic ds, input logic [15:0] d, input logic rd, input string tag);
        en0  = en;
        ds0  = ds;
        din0 = d;
        rd0  = rd;
        if (rd) begin
            if (sb.size() > 0) chk({tag, ":pop"}, 32'(dout0), 32'(sb.pop_front()));
            else m_unf = 1'b1;
        end
        if (en && !ds) begin
            if (sb.size() < 16) sb.push_back(d);
            else m_ovf = 1'b1;
        end
        tick();
        en0 = 1'b0;
        rd0 = 1'b0;
        check_state0(tag);
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        en0  = 1'b0;
        ds0  = 1'b0;
        rd0  = 1'b0;
        din0 = 16'h0;
        tick();
        tick();
        rst0 = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        rst1 = 1'b1; en1 = 1'b0; ds1 = 1'b0; rd1 = 1'b0; din1 = 16'h0;
        reset0();
        check_state0("reset");

        // Single push then pop
        step0(1'b1, 1'b0, 16'h1234, 1'b0, "push1");
        step0(1'b0, 1'b0, 16'h0000, 1'b1, "pop1");

        // Results routed to the output FIFO are ignored
        for (int i = 0; i < 5; i++) step0(1'b1, 1'b1, 16'hC000 + 16'(i), 1'b0, "dest1");

        // Fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) step0(1'b1, 1'b0, 16'(i), 1'b0, "fill");
        step0(1'b1, 1'b0, 16'hFFFF, 1'b0, "ovf");
        for (int i = 0; i < 16; i++) step0(1'b0, 1'b0, 16'h0, 1'b1, "drain");

        // Full with simultaneous push/pop: no overflow, 0xAAAA read last
        reset0();
        for (int i = 0; i < 16; i++) step0(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0, "fill2");
        step0(1'b1, 1'b0, 16'hAAAA, 1'b1, "full_pp");
        for (int i = 0; i < 16; i++) step0(1'b0, 1'b0, 16'h0, 1'b1, "drain2");

        // Empty with simultaneous push/pop: underflow, push still lands
        step0(1'b1, 1'b0, 16'h5555, 1'b1, "empty_pp");
        for (int i = 0; i < 20; i++) step0(1'b1, 1'b0, 16'h2000 + 16'(i), 1'b1, "wrap");
        step0(1'b0, 1'b0, 16'h0, 1'b1, "final_pop");
        step0(1'b0, 1'b0, 16'h0, 1'b1, "final_unf");

        // Latency-2 instance: strobe issued at t, data at t+2, visible after edge t+2
        tick();
        rst1 = 1'b0;
        chk("l2_reset:count", 32'(cnt1), 32'h0);
        chk("l2_reset:empty", 32'(empty1), 32'h1);
        en1 = 1'b1; din1 = 16'h1111;
        tick();
        en1 = 1'b0; din1 = 16'h2222;
        chk("l2_t:count", 32'(cnt1), 32'h0);
        tick();
        din1 = 16'h0BEE;
        chk("l2_t1:count", 32'(cnt1), 32'h0);
        tick();
        din1 = 16'h3333;
        chk("l2_t3:count", 32'(cnt1), 32'h1);
        chk("l2_t3:dout", 32'(dout1), 32'h0BEE);
        tick();
        chk("l2_t4:count", 32'(cnt1), 32'h1);
        chk("l2_t4:dout", 32'(dout1), 32'h0BEE);

        // Reset while a strobe is in flight discards it
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        chk("l2_rst:count", 32'(cnt1), 32'h0);
        en1 = 1'b1;
        tick();
        en1 = 1'b0;
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        din1 = 16'h0BEE;
        tick();
        chk("l2_inflight:count", 32'(cnt1), 32'h0);
        tick();
        chk("l2_inflight2:count", 32'(cnt1), 32'h0);
        chk("l2_inflight2:empty", 32'(empty1), 32'h1);

        // Strobe issued during the reset cycle is ignored
        rst1 = 1'b1;
        en1  = 1'b1;
        tick();
        rst1 = 1'b0;
        en1  = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("l2_rstcycle:count", 32'(cnt1), 32'h0);
        chk("l2_rstcycle:ovf", 32'(ovf1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
